// File: rtl/axis_register_slice_if.sv
// AXI4-Stream bundle: master drives payload and tvalid, slave drives tready.
// Params: N bytes of tdata, I/D/U bits of tid/tdest/tuser.
interface axis_if #(
  parameter int N = 1,
  parameter int I = 1,
  parameter int D = 1,
  parameter int U = 1
);
  logic           tvalid;
  logic           tready;
  logic [8*N-1:0] tdata;
  logic [N-1:0]   tstrb;
  logic [N-1:0]   tkeep;
  logic [I-1:0]   tid;
  logic [D-1:0]   tdest;
  logic [U-1:0]   tuser;
  logic           tlast;

  modport master (
    output tvalid, tdata, tstrb, tkeep,
    output tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep,
    input  tid, tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/axis_register_slice.sv
// Two-entry AXIS skid buffer: all forward signals and tready are registered.
// Ports: aclk, areset (async high), axis_in (slave), axis_out (master).
module axis_register_slice #(
  parameter int N = 1,
  parameter int I = 1,
  parameter int D = 1,
  parameter int U = 1
) (
  input  logic  aclk,
  input  logic  areset,
  axis_if.slave  axis_in,
  axis_if.master axis_out
);
  localparam int W = 8*N + 2*N + I + D + U + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state, next;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         valid_q;
  logic         ready_q;
  logic [W-1:0] in_pl;
  logic         in_hs;
  logic         out_hs;

  assign in_pl = {axis_in.tdata, axis_in.tstrb,
                  axis_in.tkeep, axis_in.tid,
                  axis_in.tdest, axis_in.tuser,
                  axis_in.tlast};

  assign in_hs  = axis_in.tvalid & ready_q;
  assign out_hs = valid_q & axis_out.tready;

  always_comb begin
    next = state;
    m_d  = m_q;
    s_d  = s_q;
    unique case (state)
      EMPTY: begin
        if (in_hs) begin
          next = BUSY;
          m_d  = in_pl;
        end
      end
      BUSY: begin
        if (in_hs && !out_hs) begin
          next = FULL;
          s_d  = in_pl;
        end else if (in_hs && out_hs) begin
          m_d = in_pl;
        end else if (out_hs) begin
          next = EMPTY;
        end
      end
      FULL: begin
        if (out_hs) begin
          next = BUSY;
          m_d  = s_q;
        end
      end
      default: next = EMPTY;
    endcase
  end

  // Flags are flops fed from next-state decode, so
  // neither output depends combinationally on the inputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= next;
      m_q     <= m_d;
      s_q     <= s_d;
      valid_q <= (next != EMPTY);
      ready_q <= (next != FULL);
    end
  end

  assign axis_in.tready  = ready_q;
  assign axis_out.tvalid = valid_q;
  assign {axis_out.tdata, axis_out.tstrb,
          axis_out.tkeep, axis_out.tid,
          axis_out.tdest, axis_out.tuser,
          axis_out.tlast} = m_q;
endmodule

// File: tb/tb_axis_register_slice.sv
// Scoreboard bench for axis_register_slice.
// Driver pushes expected beats; negedge monitor pops and checks.
module tb_axis_register_slice;
  localparam int N = 4;
  localparam int I = 2;
  localparam int D = 3;
  localparam int U = 5;
  localparam int W = 8*N + 2*N + I + D + U + 1;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axis_if #(.N(N), .I(I), .D(D), .U(U)) in_if ();
  axis_if #(.N(N), .I(I), .D(D), .U(U)) out_if ();

  axis_register_slice #(.N(N), .I(I), .D(D), .U(U)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .axis_in  (in_if),
    .axis_out (out_if)
  );

  int           total = 0;
  int           passed = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic [W-1:0] expq[$];
  int           pop_log[$];
  logic         rnd_en = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [W-1:0] out_pl();
    return {out_if.tdata, out_if.tstrb, out_if.tkeep,
            out_if.tid, out_if.tdest, out_if.tuser,
            out_if.tlast};
  endfunction

  function automatic logic [W-1:0] mk(input logic [31:0] d,
                                     input bit last);
    return {d, 4'hF, 4'hF, 2'd1, 3'd2, 5'd3, last};
  endfunction

  task automatic set_in(input logic [W-1:0] pl);
    {in_if.tdata, in_if.tstrb, in_if.tkeep,
     in_if.tid, in_if.tdest, in_if.tuser,
     in_if.tlast} = pl;
  endtask

  // Monitor: handshake values are stable at negedge
  logic         stall = 1'b0;
  logic [W-1:0] held = '0;
  always @(negedge aclk) begin
    if (areset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", {63'd0, out_if.tvalid}, 64'd1);
        check("hold_data", 64'(out_pl()), 64'(held));
      end
      if (out_if.tvalid && out_if.tready) begin
        pop_log.push_back(cyc);
        if (expq.size() == 0) begin
          total++;
          $display("FAIL extra_beat: got %h want none", out_pl());
        end else begin
          check("beat", 64'(out_pl()), 64'(expq.pop_front()));
        end
      end
      stall = out_if.tvalid && !out_if.tready;
      held = out_pl();
    end
  end

  always @(posedge aclk) begin
    if (rnd_en) begin
      #1;
      out_if.tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [W-1:0] pl);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    in_if.tvalid = 1'b1;
    set_in(pl);
    while (!ok && n < 200) begin
      @(negedge aclk);
      if (in_if.tready && !areset) begin
        ok = 1;
        expq.push_back(pl);
        acc_cyc = cyc;
      end else begin
        @(posedge aclk);
        #1;
        n++;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: got no tready want accept");
    end
    @(posedge aclk);
    #1;
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 1000) begin
      @(posedge aclk);
      n++;
    end
    if (expq.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d left want 0",
               expq.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx0;
    int first_acc;
    logic [63:0] r;
    in_if.tvalid = 1'b0;
    set_in('0);
    out_if.tready = 1'b0;

    // Reset
    repeat (3) begin
      @(negedge aclk);
      check("rst_tvalid", {63'd0, out_if.tvalid}, 64'd0);
      check("rst_tready", {63'd0, in_if.tready}, 64'd0);
    end
    check("rst_tdata", 64'(out_if.tdata), 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("tready_pre_edge", {63'd0, in_if.tready}, 64'd0);
    @(negedge aclk);
    check("tready_post_edge", {63'd0, in_if.tready}, 64'd1);
    @(posedge aclk);
    #1;

    // Streaming 0..15, no bubbles, one cycle latency
    out_if.tready = 1'b1;
    idx0 = pop_log.size();
    send(mk(32'd0, 1'b0));
    first_acc = acc_cyc;
    for (int i = 1; i < 16; i++) send(mk(32'(i), i == 15));
    drain();
    check("stream_count", 64'(pop_log.size() - idx0), 64'd16);
    if (pop_log.size() - idx0 >= 16) begin
      check("stream_span",
            64'(pop_log[idx0+15] - pop_log[idx0]), 64'd15);
      check("stream_latency",
            64'(pop_log[idx0] - first_acc), 64'd1);
    end

    // Backpressure: 0x11 on output, 0x22 in skid, 0x33 waiting
    out_if.tready = 1'b0;
    send(mk(32'h11, 1'b0));
    send(mk(32'h22, 1'b0));
    in_if.tvalid = 1'b1;
    set_in(mk(32'h33, 1'b1));
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("bp_out_data", 64'(out_if.tdata), 64'h11);
    check("bp_out_valid", {63'd0, out_if.tvalid}, 64'd1);
    check("bp_in_ready", {63'd0, in_if.tready}, 64'd0);
    @(posedge aclk);
    #1 out_if.tready = 1'b1;
    send(mk(32'h33, 1'b1));
    drain();

    // Simultaneous in/out handshake in BUSY
    send(mk(32'h40, 1'b0));
    send(mk(32'h41, 1'b1));
    @(negedge aclk);
    check("sim_out_data", 64'(out_if.tdata), 64'h41);
    check("sim_out_valid", {63'd0, out_if.tvalid}, 64'd1);
    check("sim_in_ready", {63'd0, in_if.tready}, 64'd1);
    @(posedge aclk);
    #1;
    drain();

    // Random traffic
    rnd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge aclk);
        #1;
      end
      r = {$urandom(), $urandom()};
      send(r[W-1:0]);
    end
    rnd_en = 1'b0;
    @(posedge aclk);
    #2 out_if.tready = 1'b1;
    drain();

    // Reset while FULL
    out_if.tready = 1'b0;
    send(mk(32'h77, 1'b0));
    send(mk(32'h88, 1'b0));
    #3 areset = 1'b1;
    #1;
    check("midrst_tvalid", {63'd0, out_if.tvalid}, 64'd0);
    check("midrst_tready", {63'd0, in_if.tready}, 64'd0);
    expq.delete();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk);
    #1;
    idx0 = pop_log.size();
    out_if.tready = 1'b1;
    send(mk(32'hA5, 1'b1));
    drain();
    check("post_rst_beats", 64'(pop_log.size() - idx0), 64'd1);

    check("queue_empty", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
